bus_tx_fifo_device: RTL and testbench
=====================================

// Module: bus_tx_fifo_device
// PURPOSE
// - Memory-mapped responder on one bus_hub device port; the CPU pushes words, an external stream consumer drains them.
// - Decodes its own 16-byte window and drives active; answers every accepted access with a registered one-cycle ready pulse.
// - Sits beside the program memory and parallel output as a further device slot of the hub.
// - Holds a DEPTH-word FIFO and exposes a valid/ready stream output plus a level irq.
// PARAMETERS
// BASE_ADDR  32'h0001_0000  byte base of the window; 16-byte aligned
// DEPTH      8              FIFO depth in 32-bit words; power of 2, >=2
// PORTS
// clk       in   1   clock; all state on posedge
// rst       in   1   reset: synchronous, active-low
// addr      in   32  byte address from hub
// wdata     in   32  write data
// wmask     in   4   byte write enables
// ren       in   1   read strobe
// wen       in   1   write strobe
// rdata     out  32  read data, valid while ready=1
// ready     out  1   access complete, one-cycle pulse
// active    out  1   comb: addr in [BASE_ADDR, BASE_ADDR+16)
// tx_data   out  32  FIFO head word
// tx_valid  out  1   FIFO non-empty
// tx_ready  in   1   consumer pops head when tx_valid&tx_ready
// irq       out  1   level: empty & irq_en
// BEHAVIOUR
// - Reset (rst=0 at a posedge): FIFO empty, count=0, overflow=0, irq_en=0, ready=0, rdata=0, FSM=IDLE.
// - Map (offset=addr[3:0]):
//   - 0x0 DATA W: push {wdata & byte-expanded wmask}; nothing pushed if wmask=0.
//   - 0x0 DATA R: peek head, no pop; reads 0 when empty.
//   - 0x4 STATUS R: {count[15:0], 12'b0, irq_en, overflow, full, empty}; writes ignored.
//   - 0x8 CTRL W (only if wmask[0]): bit0 flush FIFO; bit1 clear overflow; bit2 written to irq_en.
//   - 0x8 CTRL R: {29'b0, irq_en, 2'b0}.
//   - 0xC: reads 0, writes ignored; still acknowledged.
// - FSM IDLE: accept when (ren|wen)&active; side effects at that edge; rdata captured; go RESP.
// - FSM RESP: ready=1 for exactly this cycle; strobes ignored; go IDLE. Latency: ready one cycle after accept.
// - A held strobe is re-accepted the cycle after ready, so a host that never drops wen pushes every other cycle.
// - ren&wen together: write side effects apply; rdata is the pre-write value.
// - Accesses with active=0 are never accepted; ready stays 0.
// - full = (count==DEPTH), evaluated on pre-edge state.
// - Push while full: word dropped, overflow<=1 (sticky), even if a stream pop occurs the same cycle.
// - Push and pop in one cycle (not full): both happen; count unchanged.
// - Flush in the same cycle as a pop or push: flush wins; FIFO ends empty.
// - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
// - tx_data/tx_valid are combinational from storage/count; tx_data=0 when empty.
// - Stream pop is ignored when empty.
// - Reset mid-access: pending ready is dropped and no response is issued.
// TESTING
// - Reset, then read STATUS at 0x4 -> ready on cycle 2, rdata=32'h0000_0001 (empty).
// - Write 0xDEADBEEF to DATA, mask 4'b0011, tx_ready=0 -> tx_valid=1, tx_data=32'h0000_BEEF, STATUS count=1.
// - Push 9 words with DEPTH=8 and tx_ready=0 -> count=8, full=1, overflow=1, words 0..7 drain in order.
// - FIFO full and a 9th push lands on a tx_ready=1 cycle -> pop occurs, push dropped, count=7, overflow=1.
// - Write CTRL 32'h7 -> FIFO empty, overflow=0, irq_en=1, irq=1; push one word -> irq=0.
// - Hold ren at 0x4 for 4 cycles -> ready pattern 0,1,0,1; addr 0x0002_0000 -> active=0, ready never asserted.

Source files
------------

// File: rtl/bus_tx_fifo_device.sv
// bus_tx_fifo_device: memory-mapped transmit FIFO on one bus_hub device port.
// The CPU pushes words through the DATA register, and an external consumer
// drains them over a valid/ready stream. Every accepted access gets exactly
// one ready pulse, one cycle after the access is accepted.
module bus_tx_fifo_device #(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        ren,
    input  logic        wen,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        active,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;

    logic [31:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic               r_irq_en;
    logic [31:0]        r_rdata;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_push_ok;
    logic               w_pop;
    logic               w_ctrl_wr;
    logic               w_flush;
    logic               w_clr_ovf;
    logic [31:0]        w_wdata_masked;
    logic [31:0]        w_status;
    logic [31:0]        w_rdata_nxt;

    // The window is 16-byte aligned, so only the upper address bits need comparing.
    assign active   = (addr[31:4] == BASE_ADDR[31:4]);

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign tx_valid = ~w_empty;
    assign tx_data  = w_empty ? 32'h0 : r_mem[r_rptr];
    assign irq      = w_empty & r_irq_en;
    assign rdata    = r_rdata;

    assign w_wdata_masked = wdata & {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};

    // Side effects are qualified by the accept of this access only.
    assign w_push    = w_accept & wen & (addr[3:0] == 4'h0) & (wmask != 4'b0000);
    assign w_ctrl_wr = w_accept & wen & (addr[3:0] == 4'h8) & wmask[0];
    assign w_flush   = w_ctrl_wr & wdata[0];
    assign w_clr_ovf = w_ctrl_wr & wdata[1];
    // Fullness is judged on pre-edge state: a pop in the same cycle does not make room.
    assign w_push_ok = w_push & ~w_full & ~w_flush;
    assign w_pop     = tx_ready & ~w_empty;

    assign w_status = {{(16 - CNT_W){1'b0}}, r_count, 12'b0, r_irq_en, r_overflow, w_full, w_empty};

    // Read mux over pre-edge state, so a combined read/write returns the old value.
    always_comb begin
        w_rdata_nxt = 32'h0;
        case (addr[3:0])
            4'h0:    w_rdata_nxt = tx_data;
            4'h4:    w_rdata_nxt = w_status;
            4'h8:    w_rdata_nxt = {29'b0, r_irq_en, 2'b0};
            default: w_rdata_nxt = 32'h0;
        endcase
    end

    // Handshake state register; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state: accept from IDLE, always return from RESP so a held strobe re-accepts later.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if ((ren | wen) & active) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs: accept only while idle, ready for the single RESP cycle.
    always_comb begin
        w_accept = (r_state == S_IDLE) & (ren | wen) & active;
        ready    = (r_state == S_RESP);
    end

    // Read data captured at the accepting edge and held until the next access.
    always_ff @(posedge clk) begin
        if (!rst)          r_rdata <= 32'h0;
        else if (w_accept) r_rdata <= w_rdata_nxt;
    end

    // FIFO storage; contents need no reset because the count masks stale words.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= w_wdata_masked;
    end

    // Pointers and count; flush overrides a simultaneous push or pop.
    always_ff @(posedge clk) begin
        if (!rst || w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow and irq enable from the control register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow <= 1'b0;
            r_irq_en   <= 1'b0;
        end else begin
            if (w_push && w_full) r_overflow <= 1'b1;
            else if (w_clr_ovf)   r_overflow <= 1'b0;
            if (w_ctrl_wr)        r_irq_en   <= wdata[2];
        end
    end
endmodule

// File: tb/tb_bus_tx_fifo_device.sv
// Bench for bus_tx_fifo_device: directed scenarios followed by random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_bus_tx_fifo_device;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        ren;
    logic        wen;
    logic [31:0] rdata;
    logic        ready;
    logic        active;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] q[$];
    logic        m_ovf;
    logic        m_irq_en;
    logic        m_resp;
    logic [31:0] m_rdata;
    logic [31:0] g_rd;
    int          g_lat;

    bus_tx_fifo_device #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wmask(wmask),
        .ren(ren), .wen(wen), .rdata(rdata), .ready(ready), .active(active),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic in_win(logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd16);
    endfunction

    function automatic logic [31:0] expand(logic [3:0] m);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) if (m[i]) r = r | (32'hFF << (8 * i));
        return r;
    endfunction

    function automatic logic [31:0] m_status();
        int n;
        n = q.size();
        return (32'(n) << 16) | (32'(m_irq_en) << 3) | (32'(m_ovf) << 2)
             | (32'(n == DEPTH) << 1) | 32'(n == 0);
    endfunction

    function automatic logic [31:0] m_read(logic [3:0] off);
        case (off)
            4'h0:    return (q.size() > 0) ? q[0] : 32'h0;
            4'h4:    return m_status();
            4'h8:    return 32'(m_irq_en) << 2;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, update the model from the inputs seen at that edge, compare outputs.
    task automatic tick();
        logic        acc, pop, full_pre;
        logic [31:0] rd;
        logic [3:0]  off;
        chk("active", 32'(active), 32'(in_win(addr)));
        off      = addr[3:0];
        acc      = rst && !m_resp && (ren || wen) && in_win(addr);
        rd       = m_read(off);
        full_pre = (q.size() == DEPTH);
        pop      = tx_ready && (q.size() > 0);
        @(posedge clk);
        #1;
        if (!rst) begin
            q.delete();
            m_ovf = 1'b0; m_irq_en = 1'b0; m_resp = 1'b0; m_rdata = 32'h0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc && wen) begin
                if (off == 4'h0 && wmask != 4'b0) begin
                    if (full_pre) m_ovf = 1'b1;
                    else          q.push_back(wdata & expand(wmask));
                end else if (off == 4'h8 && wmask[0]) begin
                    if (wdata[1]) m_ovf = 1'b0;
                    m_irq_en = wdata[2];
                    if (wdata[0]) q.delete();
                end
            end
            m_resp = acc;
            if (acc) m_rdata = rd;
        end
        chk("ready",    32'(ready),    32'(m_resp));
        chk("rdata",    rdata,         m_rdata);
        chk("tx_valid", 32'(tx_valid), 32'(q.size() > 0));
        chk("tx_data",  tx_data,       (q.size() > 0) ? q[0] : 32'h0);
        chk("irq",      32'(irq),      32'(q.size() == 0 && m_irq_en));
        if (m_resp) g_rd = rdata;
    endtask

    // One complete bus access inside the window; bounded wait for the response.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm,
                          input logic r, input logic w);
        addr = a; wdata = wd; wmask = wm; ren = r; wen = w;
        g_lat = 0;
        do begin
            tick();
            g_lat++;
        end while (!m_resp && g_lat < 4);
        chk("access_ready", 32'(ready), 32'h1);
        ren = 1'b0; wen = 1'b0; wmask = 4'b0;
        tick();
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        rst = 1'b0; addr = 32'h0; wdata = 32'h0; wmask = 4'b0;
        ren = 1'b0; wen = 1'b0; tx_ready = 1'b0;
        m_ovf = 1'b0; m_irq_en = 1'b0; m_resp = 1'b0; m_rdata = 32'h0; g_rd = 32'h0;

        // Reset state
        tick(); tick();
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst = 1'b1;

        // STATUS after reset, ready one edge after accept
        access(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("status_reset", g_rd, 32'h0000_0001);
        chk("latency", 32'(g_lat), 32'd1);

        // Masked push
        access(BASE, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1'b1);
        chk("masked_valid", 32'(tx_valid), 32'h1);
        chk("masked_data", tx_data, 32'h0000_BEEF);
        access(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("status_cnt1", g_rd, 32'h0001_0000);

        // Overfill: nine pushes into eight slots, then drain in order
        access(BASE + 32'h8, 32'h1, 4'h1, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) access(BASE, 32'h100 + 32'(i), 4'hF, 1'b0, 1'b1);
        access(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("status_full_ovf", g_rd, 32'h0008_0006);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", tx_data, 32'h100 + 32'(i));
            tick();
        end
        tx_ready = 1'b0;
        chk("drained_empty", 32'(tx_valid), 32'h0);

        // Push while full coinciding with a stream pop
        access(BASE + 32'h8, 32'h3, 4'h1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) access(BASE, 32'h200 + 32'(i), 4'hF, 1'b0, 1'b1);
        addr = BASE; wdata = 32'h2FF; wmask = 4'hF; wen = 1'b1; tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0; wen = 1'b0; wmask = 4'h0;
        tick();
        access(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("status_full_pop", g_rd, 32'h0007_0004);
        chk("head_after_pop", tx_data, 32'h201);

        // CTRL = 7: flush, clear overflow, enable irq
        access(BASE + 32'h8, 32'h7, 4'h1, 1'b0, 1'b1);
        chk("ctrl7_irq", 32'(irq), 32'h1);
        access(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("ctrl7_status", g_rd, 32'h0000_0009);
        access(BASE + 32'h8, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("ctrl_read", g_rd, 32'h0000_0004);
        access(BASE, 32'h1234, 4'h0, 1'b0, 1'b1);
        chk("zero_mask_no_push", 32'(irq), 32'h1);
        access(BASE, 32'h55, 4'hF, 1'b0, 1'b1);
        chk("push_clears_irq", 32'(irq), 32'h0);

        // Combined read/write returns the pre-write head
        access(BASE, 32'hAA, 4'hF, 1'b1, 1'b1);
        chk("rw_prewrite", g_rd, 32'h55);

        // Held read strobe: ready 0,1,0,1
        addr = BASE + 32'h4; ren = 1'b1;
        chk("hold_r0", 32'(ready), 32'h0);
        tick(); chk("hold_r1", 32'(ready), 32'h1);
        tick(); chk("hold_r2", 32'(ready), 32'h0);
        tick(); chk("hold_r3", 32'(ready), 32'h1);
        ren = 1'b0;
        tick();

        // Outside the window: never acknowledged
        addr = 32'h0002_0000; ren = 1'b1; wen = 1'b1; wmask = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("oow_ready", 32'(ready), 32'h0);
        end
        addr = BASE + 32'h10; tick();
        addr = BASE - 32'h1;  tick();
        ren = 1'b0; wen = 1'b0; wmask = 4'h0;

        // Reset arriving with a strobe: no response
        addr = BASE + 32'h4; ren = 1'b1; rst = 1'b0;
        tick();
        chk("rst_no_ready", 32'(ready), 32'h0);
        ren = 1'b0; rst = 1'b1;
        tick();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 45)      a = BASE;
            else if (sel < 65) a = BASE + 32'h4;
            else if (sel < 78) a = BASE + 32'h8;
            else if (sel < 85) a = BASE + 32'hC;
            else if (sel < 92) a = BASE + 32'h10;
            else               a = 32'h0002_0000 + 32'($urandom_range(0, 15));
            addr     = a;
            wdata    = $urandom;
            if (a == BASE + 32'h8 && $urandom_range(0, 3) != 0) wdata[0] = 1'b0;
            wmask    = 4'($urandom);
            ren      = 1'($urandom);
            wen      = ($urandom_range(0, 9) < 6);
            tx_ready = ($urandom_range(0, 9) < 3);
            rst      = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst = 1'b1; ren = 1'b0; wen = 1'b0; tx_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
